// File: rtl/hdmi_downscaler.sv
// HDMI capture downscaler: box-filters each SUB_X x SUB_Y block of the active input window
// into one PPU-grid pixel, with a per-column accumulator line buffer and a sticky sync check.
module hdmi_downscaler #(
    parameter int ISCREEN_WIDTH  = 256,
    parameter int ISCREEN_HEIGHT = 240,
    parameter int SUB_X          = 2,
    parameter int SUB_Y          = 2,
    parameter int OSCREEN_SHIFT  = 104
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        de,
    input  logic [9:0]  hx,
    input  logic [9:0]  hy,
    input  logic [23:0] rgb_h,
    output logic [23:0] rgb_p,
    output logic [8:0]  px,
    output logic [8:0]  py,
    output logic        pvalid,
    output logic        frame_done,
    output logic        sync_err,
    output logic        state_dbg
);
    localparam int LX = $clog2(SUB_X);
    localparam int LY = $clog2(SUB_Y);
    localparam int N  = SUB_X * SUB_Y;
    localparam int LN = LX + LY;
    localparam int AW = 8 + LN;
    localparam int CW = $clog2(ISCREEN_WIDTH);

    typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;
    state_t state;

    logic [10:0]       hx_ext;
    logic [10:0]       rel_x;
    logic [10:0]       col;
    logic [10:0]       sub_col;
    logic [9:0]        sub_row;
    logic [9:0]        line;
    logic [CW-1:0]     col_idx;
    logic              in_win;
    logic              frame_start;
    logic              accept;
    logic              first_blk;
    logic              last_blk;
    logic              last_pix;
    logic [3*AW-1:0]   acc [ISCREEN_WIDTH];
    logic [3*AW-1:0]   acc_rd;
    logic [3*AW-1:0]   sum;
    logic [AW:0]       rnd;
    logic [23:0]       avg;
    logic              prev_valid;
    logic [9:0]        prev_hx;
    logic [9:0]        prev_hy;

    assign hx_ext  = {1'b0, hx};
    assign rel_x   = hx_ext - 11'(OSCREEN_SHIFT);
    assign in_win  = de && (hx_ext >= 11'(OSCREEN_SHIFT))
                        && (hx_ext < 11'(OSCREEN_SHIFT + ISCREEN_WIDTH * SUB_X))
                        && ({1'b0, hy} < 11'(ISCREEN_HEIGHT * SUB_Y));
    assign col     = rel_x >> LX;
    assign sub_col = rel_x & 11'(SUB_X - 1);
    assign sub_row = hy & 10'(SUB_Y - 1);
    assign line    = hy >> LY;
    assign col_idx = col[CW-1:0];

    assign first_blk   = (sub_row == '0) && (sub_col == '0);
    assign last_blk    = (sub_row == 10'(SUB_Y - 1)) && (sub_col == 11'(SUB_X - 1));
    assign frame_start = in_win && (hx == 10'(OSCREEN_SHIFT)) && (hy == '0);
    assign accept      = in_win && ((state == ACTIVE) || frame_start);
    assign last_pix    = last_blk && (col == 11'(ISCREEN_WIDTH - 1))
                                  && (line == 10'(ISCREEN_HEIGHT - 1));
    assign state_dbg   = (state == ACTIVE);

    // The closing sample of a block is summed combinationally, never stored and re-read.
    always_comb begin
        acc_rd = acc[col_idx];
        sum    = '0;
        rnd    = '0;
        avg    = '0;
        for (int ch = 0; ch < 3; ch++) begin
            sum[ch*AW +: AW] = (first_blk ? {AW{1'b0}} : acc_rd[ch*AW +: AW])
                               + AW'(rgb_h[ch*8 +: 8]);
            rnd = {1'b0, sum[ch*AW +: AW]} + (AW+1)'(N / 2);
            avg[ch*8 +: 8] = 8'(rnd >> LN);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ISCREEN_WIDTH; i++) acc[i] <= '0;
        end else if (accept && !last_blk) begin
            acc[col_idx] <= sum;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            rgb_p      <= '0;
            px         <= '0;
            py         <= '0;
            pvalid     <= 1'b0;
            frame_done <= 1'b0;
            sync_err   <= 1'b0;
            prev_valid <= 1'b0;
            prev_hx    <= '0;
            prev_hy    <= '0;
        end else begin
            pvalid     <= 1'b0;
            frame_done <= 1'b0;
            if (accept) begin
                prev_valid <= 1'b1;
                prev_hx    <= hx;
                prev_hy    <= hy;
                // A new line restarts at OSCREEN_SHIFT, so only in-line steps are checked.
                if ((state == ACTIVE) && prev_valid && (hy == prev_hy)
                    && (hx != 10'(OSCREEN_SHIFT)) && (hx != prev_hx + 10'd1))
                    sync_err <= 1'b1;
                if (last_blk) begin
                    pvalid <= 1'b1;
                    rgb_p  <= avg;
                    px     <= col[8:0];
                    py     <= line[8:0];
                end
                if (frame_start) begin
                    state <= ACTIVE;
                end else if (last_pix) begin
                    frame_done <= 1'b1;
                    state      <= IDLE;
                    prev_valid <= 1'b0;
                end
            end
        end
    end
endmodule
